// File: rtl/mult_seq_arbiter.sv
// Round-robin sequencer for the shared 32x32 signed/unsigned multiplier; captures the product into HI/LO.
// Optional macro MULT_SEQ_ACC_EN adds ACC0/ACC1 for multiply-accumulate (MADD/MADDU) captures.
module mult_seq_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ0,
    input  logic        SIGNED0,
    input  logic [31:0] A0,
    input  logic [31:0] B0,
    output logic        GNT0,
    input  logic        REQ1,
    input  logic        SIGNED1,
    input  logic [31:0] A1,
    input  logic [31:0] B1,
    output logic        GNT1,
`ifdef MULT_SEQ_ACC_EN
    input  logic        ACC0,
    input  logic        ACC1,
`endif
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        DONE,
    output logic        DONE_ID,
    output logic        BUSY,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        CPL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

    // Handshake: a requester raises REQ with stable operands and keeps them until it
    // sees its one-cycle GNT; operands are latched on the edge that raises GNT.
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             id_q;
    logic             sgn_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
`ifdef MULT_SEQ_ACC_EN
    logic             acc_q;
`endif

    logic             win;
    logic             any_req;
    logic signed [63:0] a_ext_s;
    logic signed [63:0] b_ext_s;
    logic signed [63:0] prod_s;
    logic [63:0]      prod_u;
    logic [63:0]      prod;
    logic [63:0]      next_hilo;

    // A lone requester wins outright; on a tie the one not granted last time wins.
    always_comb begin
        any_req = REQ0 | REQ1;
        if (REQ0 && REQ1) begin
            win = ~last;
        end else begin
            win = REQ1;
        end
    end

    // Both multiplier flavours see the same latched operands; SIGNED picks the result.
    always_comb begin
        a_ext_s = $signed({{32{a_q[31]}}, a_q});
        b_ext_s = $signed({{32{b_q[31]}}, b_q});
        prod_s  = a_ext_s * b_ext_s;
        prod_u  = {32'd0, a_q} * {32'd0, b_q};
        prod    = sgn_q ? prod_s : prod_u;
`ifdef MULT_SEQ_ACC_EN
        next_hilo = acc_q ? ({HI, LO} + prod) : prod;
`else
        next_hilo = prod;
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            cnt     <= '0;
            last    <= 1'b1;
            id_q    <= 1'b0;
            sgn_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
`ifdef MULT_SEQ_ACC_EN
            acc_q   <= 1'b0;
`endif
            HI      <= '0;
            LO      <= '0;
            GNT0    <= 1'b0;
            GNT1    <= 1'b0;
            DONE    <= 1'b0;
            DONE_ID <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        id_q  <= win;
                        sgn_q <= win ? SIGNED1 : SIGNED0;
                        a_q   <= win ? A1 : A0;
                        b_q   <= win ? B1 : B0;
`ifdef MULT_SEQ_ACC_EN
                        acc_q <= win ? ACC1 : ACC0;
`endif
                        cnt   <= CNT_INIT;
                        GNT0  <= ~win;
                        GNT1  <= win;
                        last  <= win;
                        BUSY  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    GNT0 <= 1'b0;
                    GNT1 <= 1'b0;
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        {HI, LO} <= next_hilo;
                        DONE     <= 1'b1;
                        DONE_ID  <= id_q;
                        state    <= CPL;
                    end
                end
                CPL: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    GNT0  <= 1'b0;
                    GNT1  <= 1'b0;
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_mult_seq_arbiter.sv
// Directed bench for mult_seq_arbiter: vector table of single operations plus reset,
// round-robin and (with MULT_SEQ_ACC_EN) accumulate sequences.
module tb_mult_seq_arbiter;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req0 = 1'b0, signed0 = 1'b0, req1 = 1'b0, signed1 = 1'b0;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        gnt0, gnt1, done, done_id, busy;
    logic [31:0] hi, lo;
    logic [1:0]  dbg_state;
`ifdef MULT_SEQ_ACC_EN
    logic        acc0 = 1'b0, acc1 = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        bit          id;
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[10];

    mult_seq_arbiter #(.WAIT_CYCLES(W), .CNT_W(4)) dut (
        .CLK(clk), .RST(rst_n),
        .REQ0(req0), .SIGNED0(signed0), .A0(a0), .B0(b0), .GNT0(gnt0),
        .REQ1(req1), .SIGNED1(signed1), .A1(a1), .B1(b1), .GNT1(gnt1),
`ifdef MULT_SEQ_ACC_EN
        .ACC0(acc0), .ACC1(acc1),
`endif
        .HI(hi), .LO(lo), .DONE(done), .DONE_ID(done_id), .BUSY(busy),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One operation from a single requester, checking grant, settle, capture and release timing.
    task automatic do_op(input bit id, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input bit acc, input logic [63:0] exp, input string tag);
        int lat;
        bit got;
        @(negedge clk);
        if (id == 1'b0) begin
            req0 = 1'b1; signed0 = sgn; a0 = a; b0 = b;
        end else begin
            req1 = 1'b1; signed1 = sgn; a1 = a; b1 = b;
        end
`ifdef MULT_SEQ_ACC_EN
        if (id == 1'b0) acc0 = acc; else acc1 = acc;
`else
        if (acc) $display("note: %s requests accumulate in a build without it", tag);
`endif
        exp_q.push_back(exp);
        got = 1'b0;
        lat = 0;
        while (!got && lat < 10) begin
            @(posedge clk); #1;
            lat++;
            got = id ? gnt1 : gnt0;
        end
        check({tag, "/grant_latency"}, 64'(lat), 64'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        if (!got) begin
            void'(exp_q.pop_front());
            return;
        end
        // Scramble the inputs: the captured operands must be the latched ones.
        a0 = ~a; b0 = ~b; a1 = ~a; b1 = ~b; signed0 = ~sgn; signed1 = ~sgn;
        check({tag, "/other_gnt"}, 64'(id ? gnt0 : gnt1), 64'd0);
        check({tag, "/busy_at_grant"}, 64'(busy), 64'd1);
        for (int k = 1; k < W; k++) begin
            @(posedge clk); #1;
            check({tag, "/early_done"}, 64'(done), 64'd0);
            check({tag, "/gnt_pulse"}, 64'(gnt0 | gnt1), 64'd0);
        end
        @(posedge clk); #1;
        check({tag, "/done"}, 64'(done), 64'd1);
        check({tag, "/done_id"}, 64'(done_id), 64'(id));
        check({tag, "/product"}, {hi, lo}, exp_q.pop_front());
        check({tag, "/busy_at_done"}, 64'(busy), 64'd1);
        @(posedge clk); #1;
        check({tag, "/done_drop"}, 64'(done), 64'd0);
        check({tag, "/busy_drop"}, 64'(busy), 64'd0);
        check({tag, "/product_hold"}, {hi, lo}, exp);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int gnt_ids[8];
        int gnt_cyc[8];
        int ng;
        int nd;
        int dc;

        vecs[0] = '{1'b0, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFF1, 64'h000000000000002D};
        vecs[1] = '{1'b1, 1'b1, 32'h90000000, 32'h70000000, 64'hCF00000000000000};
        vecs[2] = '{1'b1, 1'b0, 32'h90000000, 32'h70000000, 64'h3F00000000000000};
        vecs[3] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
        vecs[4] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001};
        vecs[5] = '{1'b1, 1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF80000000};
        vecs[6] = '{1'b0, 1'b0, 32'h80000000, 32'h00000002, 64'h0000000100000000};
        vecs[7] = '{1'b1, 1'b1, 32'h00000007, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFF9};
        vecs[8] = '{1'b0, 1'b0, 32'h00000000, 32'h12345678, 64'h0000000000000000};
        vecs[9] = '{1'b1, 1'b1, 32'h12345678, 32'h00000010, 64'h0000000123456780};

        // Power-on reset and reset values
        #2 rst_n = 1'b0;
        #1;
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_ctrl", {59'd0, gnt0, gnt1, done, done_id, busy}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].id, vecs[i].sgn, vecs[i].a, vecs[i].b, 1'b0, vecs[i].exp,
                  $sformatf("vec%0d", i));
        end

        // Reset asserted mid-cycle during CALC of 10*20: immediate clear, no DONE afterwards
        @(negedge clk);
        req0 = 1'b1; signed0 = 1'b0; a0 = 32'd10; b0 = 32'd20;
        @(posedge clk); #1;
        check("rst_mid/grant", 64'(gnt0), 64'd1);
        req0 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid/hilo", {hi, lo}, 64'd0);
        check("rst_mid/ctrl", {59'd0, gnt0, gnt1, done, done_id, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done) dc++;
        end
        check("rst_mid/no_done", 64'(dc), 64'd0);
        check("rst_mid/hilo_after", {hi, lo}, 64'd0);
        do_op(1'b0, 1'b0, 32'd10, 32'd20, 1'b0, 64'hC8, "after_rst");

        // Both requesters held from reset: strict alternation, grants W+2 edges apart
        pulse_reset();
        @(negedge clk);
        req0 = 1'b1; signed0 = 1'b1; a0 = 32'd2; b0 = 32'd3;
        req1 = 1'b1; signed1 = 1'b0; a1 = 32'd5; b1 = 32'd7;
        ng = 0;
        nd = 0;
        for (int cyc = 1; cyc <= 40 && nd < 4; cyc++) begin
            @(posedge clk); #1;
            if (gnt0 && gnt1) check("rr/dual_grant", 64'd1, 64'd0);
            if ((gnt0 || gnt1) && ng < 8) begin
                gnt_ids[ng] = gnt1 ? 1 : 0;
                gnt_cyc[ng] = cyc;
                ng++;
                if (ng == 4) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
            if (done) begin
                check($sformatf("rr/product%0d", nd), {hi, lo}, done_id ? 64'd35 : 64'd6);
                check($sformatf("rr/done_id%0d", nd), 64'(done_id), 64'(nd % 2));
                nd++;
            end
        end
        check("rr/grant_count", 64'(ng), 64'd4);
        check("rr/done_count", 64'(nd), 64'd4);
        for (int g = 0; g < 4 && g < ng; g++) begin
            check($sformatf("rr/order%0d", g), 64'(gnt_ids[g]), 64'(g % 2));
            if (g > 0)
                check($sformatf("rr/spacing%0d", g), 64'(gnt_cyc[g] - gnt_cyc[g-1]), 64'(W + 2));
        end

`ifdef MULT_SEQ_ACC_EN
        // Multiply-accumulate chain
        do_op(1'b0, 1'b0, 32'd10, 32'd20, 1'b0, 64'h00000000000000C8, "acc_load");
        do_op(1'b1, 1'b0, 32'd3, 32'd15, 1'b1, 64'h00000000000000F5, "acc_add");
        do_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFE000000F6, "acc_big");
`endif

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
